voice_scheduler: RTL

Polyphonic voice scheduler for the piano audio path. It sits between the seven key inputs (`SW[6:0]`) and the `Audio_Controller` write port, and replaces the fixed one-generator-per-key tone logic. It assigns pressed keys to a limited pool of square-wave voices, mixes the active voices and delivers samples to the codec FIFO through the `audio_out_allowed` / `write_audio_out` handshake.

---
 rtl/piano_pkg.sv | 28 ++
 rtl/square_voice.sv | 69 ++++++
 rtl/voice_scheduler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/piano_pkg.sv
// Shared constants and types for the piano audio path.
package piano_pkg;

  localparam int unsigned KEY_W    = 3;
  localparam int unsigned CNT_W    = 17;
  localparam int unsigned SAMPLE_W = 32;

  localparam logic signed [SAMPLE_W-1:0] AMPLITUDE = 32'sd100000000;

  typedef logic [KEY_W-1:0] key_idx_t;

  // Half-period in clock cycles for each key; index 6 = C down to 0 = B.
  function automatic logic [CNT_W-1:0] get_half_period(key_idx_t k);
    logic [CNT_W-1:0] hp;
    case (k)
      3'd6:    hp = 17'd96000;
      3'd5:    hp = 17'd86000;
      3'd4:    hp = 17'd76000;
      3'd3:    hp = 17'd71500;
      3'd2:    hp = 17'd64000;
      3'd1:    hp = 17'd57000;
      3'd0:    hp = 17'd51000;
      default: hp = '0;
    endcase
    return hp;
  endfunction

endpackage

// File: rtl/square_voice.sv
// One square-wave voice: phase counter, polarity and registered output sample.
// load restarts the voice at phase 0 with positive polarity and wins over stop.
module square_voice
  import piano_pkg::*;
(
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       load,
  input  logic                       stop,
  input  logic [CNT_W-1:0]           half_period,
  output logic                       active,
  output logic signed [SAMPLE_W-1:0] sample
);

  logic                       active_q, active_d;
  logic                       pol_q, pol_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;

  // Next-state for phase counter and polarity; output follows the new state.
  always_comb begin
    active_d = active_q;
    pol_d    = pol_q;
    cnt_d    = cnt_q;
    if (load) begin
      active_d = 1'b1;
      pol_d    = 1'b1;
      cnt_d    = '0;
    end else if (stop) begin
      active_d = 1'b0;
      pol_d    = 1'b1;
      cnt_d    = '0;
    end else if (active_q) begin
      if (cnt_q >= half_period) begin
        cnt_d = '0;
        pol_d = ~pol_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (!active_d) begin
      sample_d = '0;
    end else if (pol_d) begin
      sample_d = AMPLITUDE;
    end else begin
      sample_d = -AMPLITUDE;
    end
  end

  // Voice state registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      active_q <= 1'b0;
      pol_q    <= 1'b1;
      cnt_q    <= '0;
      sample_q <= '0;
    end else begin
      active_q <= active_d;
      pol_q    <= pol_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
    end
  end

  assign active = active_q;
  assign sample = sample_q;

endmodule

// File: rtl/voice_scheduler.sv
// Polyphonic voice scheduler: edge-detects keys, allocates at most one voice
// per cycle (highest pending key first, lowest idle voice), mixes the voices
// and hands samples to the codec FIFO.
// Build option: define VOICE_STEAL_EN to steal the oldest voice when the pool
// is full; otherwise a key arriving at a full pool is dropped.
module voice_scheduler
  import piano_pkg::*;
#(
  parameter int unsigned NUM_KEYS   = 7,
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned AGE_W      = 4
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [NUM_KEYS-1:0]        key_in,
  input  logic                       audio_out_allowed,
  output logic                       write_audio_out,
  output logic signed [SAMPLE_W-1:0] left_channel_audio_out,
  output logic signed [SAMPLE_W-1:0] right_channel_audio_out,
  output logic [NUM_VOICES-1:0]      voice_active,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key
);

  localparam int unsigned VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  typedef logic [VIDX_W-1:0] vidx_t;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [NUM_KEYS-1:0] key_q;
  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic [NUM_KEYS-1:0] rise, fall, pend_eff, svc_mask;

  key_idx_t             voice_key_q [NUM_VOICES];
  key_idx_t             voice_key_d [NUM_VOICES];
  logic [AGE_W-1:0]     age_q       [NUM_VOICES];
  logic [AGE_W-1:0]     age_d       [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] sample [NUM_VOICES];

  logic [NUM_VOICES-1:0] load, stop;

  logic     svc_valid;
  key_idx_t svc_key;
  logic     idle_found;
  vidx_t    idle_idx;
  logic     tgt_valid;
  vidx_t    tgt_idx;

  logic signed [SAMPLE_W-1:0] mix_q, mix_d;
  logic                       write_q, write_d;
  logic signed [SAMPLE_W-1:0] out_q;

  // Key edges; a rise this cycle is eligible for allocation this cycle.
  always_comb begin
    rise     = key_in & ~key_q;
    fall     = ~key_in & key_q;
    pend_eff = (pending_q | rise) & ~fall;
  end

  // Pick the key to service and the voice that receives it.
  always_comb begin
    svc_valid  = 1'b0;
    svc_key    = '0;
    idle_found = 1'b0;
    idle_idx   = '0;
    tgt_valid  = 1'b0;
    tgt_idx    = '0;

    // Ascending scan: the last hit is the highest index.
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (pend_eff[k]) begin
        svc_valid = 1'b1;
        svc_key   = key_idx_t'(k);
      end
    end

    // Descending scan: the last hit is the lowest idle voice.
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!voice_active[v]) begin
        idle_found = 1'b1;
        idle_idx   = vidx_t'(v);
      end
    end

`ifdef VOICE_STEAL_EN
    begin
      logic [AGE_W-1:0] old_age;
      vidx_t            old_idx;
      old_age = '0;
      old_idx = '0;
      // Strict compare keeps the lowest index on ties.
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (age_q[v] > old_age) begin
          old_age = age_q[v];
          old_idx = vidx_t'(v);
        end
      end
      tgt_valid = svc_valid;
      tgt_idx   = idle_found ? idle_idx : old_idx;
    end
`else
    tgt_valid = svc_valid & idle_found;
    tgt_idx   = idle_idx;
`endif

    svc_mask  = svc_valid ? (NUM_KEYS'(1) << svc_key) : '0;
    pending_d = pend_eff & ~svc_mask;
  end

  // Per-voice load/stop strobes, key registers and ages.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      load[v]        = tgt_valid && (tgt_idx == vidx_t'(v));
      stop[v]        = voice_active[v] && fall[voice_key_q[v]];
      voice_key_d[v] = load[v] ? svc_key : voice_key_q[v];
      age_d[v]       = age_q[v];
      if (load[v]) begin
        age_d[v] = '0;
      end else if (tgt_valid && voice_active[v] && (age_q[v] != AGE_MAX)) begin
        age_d[v] = age_q[v] + 1'b1;
      end
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    square_voice u_voice (
      .clock       (clock),
      .resetn      (resetn),
      .load        (load[v]),
      .stop        (stop[v]),
      .half_period (get_half_period(voice_key_q[v])),
      .active      (voice_active[v]),
      .sample      (sample[v])
    );
  end

  // Mixer sum and write strobe; the strobe self-clears so writes are spaced.
  always_comb begin
    mix_d = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      mix_d = mix_d + sample[v];
    end
    write_d = audio_out_allowed & ~write_q;
  end

  // Scheduler state registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_q     <= '0;
      pending_q <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        voice_key_q[v] <= '0;
        age_q[v]       <= '0;
      end
    end else begin
      key_q     <= key_in;
      pending_q <= pending_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        voice_key_q[v] <= voice_key_d[v];
        age_q[v]       <= age_d[v];
      end
    end
  end

  // Mix and output registers; channel sample captured with the strobe.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mix_q   <= '0;
      write_q <= 1'b0;
      out_q   <= '0;
    end else begin
      mix_q   <= mix_d;
      write_q <= write_d;
      if (write_d) begin
        out_q <= mix_q;
      end
    end
  end

  // Flatten voice keys: voice v occupies bits [3v+2:3v].
  always_comb begin
    voice_key = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_key[KEY_W*v +: KEY_W] = voice_key_q[v];
    end
  end

  assign write_audio_out         = write_q;
  assign left_channel_audio_out  = out_q;
  assign right_channel_audio_out = out_q;

endmodule
